// File: rtl/l15_line_serializer.sv
// l15_line_serializer: turns one D-cache line into a sequence of NoC beats.
// A line is captured in IDLE, then sent beat by beat in SEND, either in
// linear order or critical-beat-first with wrap-around. Each beat can be
// byte-swapped for a big-endian NoC.
module l15_line_serializer #(
  parameter int LineWidth = 128,
  parameter int BeatWidth = 64,
  parameter int AddrWidth = 64,
  parameter bit BigEndian = 1'b1,
  parameter bit CritFirst = 1'b0,
  localparam int NBeats   = LineWidth / BeatWidth,
  localparam int IdxW     = (NBeats > 1) ? $clog2(NBeats) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 line_valid_i,
  output logic                 line_ready_o,
  input  logic [LineWidth-1:0] line_data_i,
  input  logic [AddrWidth-1:0] line_addr_i,
  output logic                 beat_valid_o,
  input  logic                 beat_ready_i,
  output logic [BeatWidth-1:0] beat_data_o,
  output logic [AddrWidth-1:0] beat_addr_o,
  output logic [IdxW-1:0]      beat_idx_o,
  output logic                 beat_last_o,
  input  logic                 flush_i
);

  localparam int NBytes   = BeatWidth / 8;
  localparam int OffW     = $clog2(BeatWidth / 8);
  localparam int LineOffW = $clog2(LineWidth / 8);

  // Clears the byte offset within the line to form the line-aligned base.
  localparam logic [AddrWidth-1:0] LineMask =
    {{(AddrWidth - LineOffW){1'b1}}, {LineOffW{1'b0}}};

  // The beat counter must be able to count every beat of a line, and the
  // index arithmetic relies on modulo-2^IdxW wrap, so reject bad geometry.
  if (NBeats < 2 || (NBeats & (NBeats - 1)) != 0 || LineWidth != NBeats * BeatWidth) begin : g_bad_params
    $error("l15_line_serializer: NBeats must be a power of 2 and at least 2");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [BeatWidth-1:0]   beats_q [NBeats];
  logic [AddrWidth-1:0]   base_q;
  logic [IdxW-1:0]        idx_q;
  logic [IdxW-1:0]        cnt_q;
  logic [IdxW-1:0]        start_idx;
  logic                   accept;
  logic                   advance;
  logic                   at_last;
  logic                   out_en;
  logic [BeatWidth-1:0]   slice;
  logic [BeatWidth-1:0]   swapped;

  // In critical-first mode the beat holding the requested address goes out first.
  always_comb begin
    start_idx = '0;
    if (CritFirst) begin
      start_idx = line_addr_i[OffW+IdxW-1:OffW];
    end
  end

  assign at_last = (cnt_q == IdxW'(NBeats - 1));

  // State register; reset forces IDLE so any line in flight is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode; flush wins over a beat handshake.
  always_comb begin
    state_d      = state_q;
    line_ready_o = 1'b0;
    beat_valid_o = 1'b0;
    accept       = 1'b0;
    advance      = 1'b0;
    case (state_q)
      IDLE: begin
        line_ready_o = ~rst_i;
        if (line_valid_i && !rst_i) begin
          accept  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        beat_valid_o = ~rst_i;
        if (flush_i) begin
          state_d = IDLE;
        end else if (beat_ready_i) begin
          advance = 1'b1;
          if (at_last) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line capture on acceptance, and index/counter stepping on each sent beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      for (int k = 0; k < NBeats; k++) begin
        beats_q[k] <= '0;
      end
    end else if (accept) begin
      base_q <= line_addr_i & LineMask;
      idx_q  <= start_idx;
      cnt_q  <= '0;
      for (int k = 0; k < NBeats; k++) begin
        beats_q[k] <= line_data_i[k*BeatWidth +: BeatWidth];
      end
    end else if (advance) begin
      idx_q <= idx_q + IdxW'(1);
      cnt_q <= cnt_q + IdxW'(1);
    end
  end

  // Select the current beat and optionally reverse its bytes for the NoC.
  always_comb begin
    slice   = beats_q[idx_q];
    swapped = slice;
    if (BigEndian) begin
      for (int b = 0; b < NBytes; b++) begin
        swapped[b*8 +: 8] = slice[(NBytes-1-b)*8 +: 8];
      end
    end
  end

  assign out_en = (state_q == SEND) && !rst_i;

  // Beat outputs are only meaningful in SEND and read as zero otherwise.
  always_comb begin
    beat_data_o = '0;
    beat_addr_o = '0;
    beat_idx_o  = '0;
    beat_last_o = 1'b0;
    if (out_en) begin
      beat_data_o = swapped;
      beat_addr_o = base_q | (AddrWidth'(idx_q) << OffW);
      beat_idx_o  = idx_q;
      beat_last_o = at_last;
    end
  end

endmodule

// File: tb/tb_l15_line_serializer.sv
// Directed testbench for l15_line_serializer. Three instances share stimulus:
// linear little-endian, critical-first little-endian, linear big-endian.
module tb_l15_line_serializer;

  logic         clk;
  logic         rst;
  logic         line_valid;
  logic [127:0] line_data;
  logic [63:0]  line_addr;
  logic         beat_ready;
  logic         flush;

  logic         ready_lin, valid_lin, last_lin;
  logic [63:0]  data_lin, addr_lin;
  logic [0:0]   idx_lin;

  logic         ready_crit, valid_crit, last_crit;
  logic [63:0]  data_crit, addr_crit;
  logic [0:0]   idx_crit;

  logic         ready_be, valid_be, last_be;
  logic [63:0]  data_be, addr_be;
  logic [0:0]   idx_be;

  int num_compared   = 0;
  int num_mismatched = 0;

  l15_line_serializer #(.LineWidth(128), .BeatWidth(64), .AddrWidth(64),
                        .BigEndian(1'b0), .CritFirst(1'b0)) dut_lin (
    .clk_i(clk), .rst_i(rst), .line_valid_i(line_valid), .line_ready_o(ready_lin),
    .line_data_i(line_data), .line_addr_i(line_addr), .beat_valid_o(valid_lin),
    .beat_ready_i(beat_ready), .beat_data_o(data_lin), .beat_addr_o(addr_lin),
    .beat_idx_o(idx_lin), .beat_last_o(last_lin), .flush_i(flush));

  l15_line_serializer #(.LineWidth(128), .BeatWidth(64), .AddrWidth(64),
                        .BigEndian(1'b0), .CritFirst(1'b1)) dut_crit (
    .clk_i(clk), .rst_i(rst), .line_valid_i(line_valid), .line_ready_o(ready_crit),
    .line_data_i(line_data), .line_addr_i(line_addr), .beat_valid_o(valid_crit),
    .beat_ready_i(beat_ready), .beat_data_o(data_crit), .beat_addr_o(addr_crit),
    .beat_idx_o(idx_crit), .beat_last_o(last_crit), .flush_i(flush));

  l15_line_serializer #(.LineWidth(128), .BeatWidth(64), .AddrWidth(64),
                        .BigEndian(1'b1), .CritFirst(1'b0)) dut_be (
    .clk_i(clk), .rst_i(rst), .line_valid_i(line_valid), .line_ready_o(ready_be),
    .line_data_i(line_data), .line_addr_i(line_addr), .beat_valid_o(valid_be),
    .beat_ready_i(beat_ready), .beat_data_o(data_be), .beat_addr_o(addr_be),
    .beat_idx_o(idx_be), .beat_last_o(last_be), .flush_i(flush));

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    num_compared++;
    if (observed !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive all inputs at once and let combinational outputs settle.
  task automatic applyStimulus(input logic valid, input logic [127:0] data,
                               input logic [63:0] addr, input logic bready,
                               input logic fl);
    line_valid = valid;
    line_data  = data;
    line_addr  = addr;
    beat_ready = bready;
    flush      = fl;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check every output of the linear little-endian instance.
  task automatic checkLinear(input string tag, input logic v, input logic [63:0] d,
                             input logic [63:0] a, input logic i, input logic l);
    checkOutput({tag, ".valid"}, valid_lin, v);
    checkOutput({tag, ".data"},  data_lin,  d);
    checkOutput({tag, ".addr"},  addr_lin,  a);
    checkOutput({tag, ".idx"},   idx_lin,   i);
    checkOutput({tag, ".last"},  last_lin,  l);
  endtask

  initial begin
    // Reset held two cycles with a line on offer: nothing may be accepted.
    rst = 1'b1;
    applyStimulus(1'b1, {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555},
                  64'h8000_0010, 1'b1, 1'b0);
    step();
    checkOutput("rst.ready", ready_lin, 1'b0);
    checkLinear("rst", 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    step();
    checkOutput("rst2.ready", ready_lin, 1'b0);
    checkOutput("rst2.valid", valid_lin, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 128'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("post_rst.ready", ready_lin, 1'b1);
    checkOutput("post_rst.valid", valid_lin, 1'b0);
    step();
    checkOutput("post_rst.no_accept", valid_lin, 1'b0);

    // Linear send of a two-beat line.
    applyStimulus(1'b1, {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555},
                  64'h8000_0010, 1'b1, 1'b0);
    checkOutput("lin.ready", ready_lin, 1'b1);
    step();
    applyStimulus(1'b0, 128'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("lin.busy", ready_lin, 1'b0);
    checkLinear("lin.b0", 1'b1, 64'h5555_5555_5555_5555, 64'h8000_0010, 1'b0, 1'b0);
    checkOutput("lin.crit_b0_idx", idx_crit, 1'b0);
    step();
    checkLinear("lin.b1", 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h8000_0018, 1'b1, 1'b1);
    step();
    checkOutput("lin.done.valid", valid_lin, 1'b0);
    checkOutput("lin.done.ready", ready_lin, 1'b1);

    // Critical-first wrap, big-endian swap and three cycles of backpressure.
    applyStimulus(1'b1, {64'hAAAA_AAAA_AAAA_AAAA, 64'h0011_2233_4455_6677},
                  64'h8000_0018, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 128'h0, 64'h0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checkLinear($sformatf("bp%0d", c), 1'b1, 64'h0011_2233_4455_6677,
                  64'h8000_0010, 1'b0, 1'b0);
      checkOutput($sformatf("bp%0d.crit_idx", c),  idx_crit,  1'b1);
      checkOutput($sformatf("bp%0d.crit_addr", c), addr_crit, 64'h8000_0018);
      checkOutput($sformatf("bp%0d.crit_last", c), last_crit, 1'b0);
      checkOutput($sformatf("bp%0d.crit_data", c), data_crit, 64'hAAAA_AAAA_AAAA_AAAA);
      checkOutput($sformatf("bp%0d.be_data", c),   data_be,   64'h7766_5544_3322_1100);
      step();
    end
    applyStimulus(1'b0, 128'h0, 64'h0, 1'b1, 1'b0);
    checkLinear("bp.still_b0", 1'b1, 64'h0011_2233_4455_6677, 64'h8000_0010, 1'b0, 1'b0);
    step();
    checkLinear("bp.b1", 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h8000_0018, 1'b1, 1'b1);
    checkOutput("crit.wrap_idx",  idx_crit,  1'b0);
    checkOutput("crit.wrap_addr", addr_crit, 64'h8000_0010);
    checkOutput("crit.wrap_last", last_crit, 1'b1);
    checkOutput("crit.wrap_data", data_crit, 64'h0011_2233_4455_6677);
    step();
    checkOutput("bp.done.valid", valid_lin, 1'b0);

    // Flush coinciding with the first beat handshake drops the rest of the line.
    applyStimulus(1'b1, {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222},
                  64'h8000_0040, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 128'h0, 64'h0, 1'b1, 1'b1);
    checkLinear("fl.b0", 1'b1, 64'h2222_2222_2222_2222, 64'h8000_0040, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, {64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444},
                  64'h8000_0080, 1'b1, 1'b0);
    checkOutput("fl.idle.valid", valid_lin, 1'b0);
    checkOutput("fl.idle.ready", ready_lin, 1'b1);
    step();
    applyStimulus(1'b0, 128'h0, 64'h0, 1'b1, 1'b0);
    checkLinear("fl.new_b0", 1'b1, 64'h4444_4444_4444_4444, 64'h8000_0080, 1'b0, 1'b0);
    step();
    checkLinear("fl.new_b1", 1'b1, 64'h3333_3333_3333_3333, 64'h8000_0088, 1'b1, 1'b1);
    step();

    // Flush while idle is ignored and the offered line is still taken.
    applyStimulus(1'b1, {64'h6666_6666_6666_6666, 64'h7777_7777_7777_7777},
                  64'h8000_00C0, 1'b0, 1'b1);
    checkOutput("fl_idle.ready", ready_lin, 1'b1);
    step();
    applyStimulus(1'b0, 128'h0, 64'h0, 1'b1, 1'b0);
    checkLinear("fl_idle.b0", 1'b1, 64'h7777_7777_7777_7777, 64'h8000_00C0, 1'b0, 1'b0);
    step();

    // Reset during SEND: outputs forced low, line dropped, ready right after.
    checkLinear("rs.b1", 1'b1, 64'h6666_6666_6666_6666, 64'h8000_00C8, 1'b1, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 128'h0, 64'h0, 1'b0, 1'b0);
    checkLinear("rs.in_rst", 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    checkOutput("rs.in_rst.ready", ready_lin, 1'b0);
    step();
    rst = 1'b0;
    applyStimulus(1'b0, 128'h0, 64'h0, 1'b0, 1'b0);
    checkOutput("rs.after.ready", ready_lin, 1'b1);
    checkOutput("rs.after.valid", valid_lin, 1'b0);
    step();
    checkOutput("rs.dropped.valid", valid_lin, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
